// File: rtl/instr_loader.sv
// instr_loader: assembles 16-bit instructions from a byte stream (high byte
// first) and buffers them in a first-word-fall-through FIFO for the core.
// A flush discards everything buffered plus any half-assembled word; losing a
// half word to a flush raises the sticky drop_err flag.
module instr_loader #(
    parameter int DEPTH = 4,   // FIFO depth in words, power of two, 2..16
    parameter int IW    = 16   // instruction width, two bytes
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_byte,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [IW-1:0]              instr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Assembler state: which half of the instruction the next byte supplies.
    typedef enum logic {
        ST_HI = 1'b0,   // next byte is [15:8]
        ST_LO = 1'b1    // next byte is [7:0]
    } state_t;

    state_t          state;
    logic [7:0]      hold;
    logic [IW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic            accept;
    logic            push;
    logic            pop;

    // Handshake decode from registered state. A low byte is refused while the
    // FIFO is full, judged on the registered count only (no pop bypass).
    // During a flush the byte is swallowed, so in_ready is forced high.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        in_ready = 1'b1;
        if (!flush && state == ST_LO && count == FULL)
            in_ready = 1'b0;
        accept = in_valid && in_ready && !flush;
        push   = accept && (state == ST_LO);
        pop    = (count != '0) && instr_ready && !flush;
    end

    // Fall-through head: the oldest word is visible whenever the FIFO is
    // non-empty, and reads zero when empty so stale storage never leaks out.
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? mem[rd_ptr] : '0;

    // Two-state byte assembler plus the sticky drop flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= ST_HI;
            hold     <= '0;
            drop_err <= 1'b0;
        end else if (flush) begin
            if (state == ST_LO)
                drop_err <= 1'b1;
            state <= ST_HI;
        end else if (accept) begin
            case (state)
                ST_HI: begin
                    hold  <= in_byte;
                    state <= ST_LO;
                end
                ST_LO: begin
                    state <= ST_HI;
                end
                default: begin
                    state <= ST_HI;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH because
    // DEPTH is a power of two. Push when full cannot happen: in_ready is low.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: written on the low-byte edge with the completed word.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; it is only observed through
        // instr, which is gated to zero while count is zero.
        if (!rst && push)
            mem[wr_ptr] <= {hold, in_byte};
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed scenarios followed by randomized traffic, all
// compared every cycle against a queue-based model of the loader.
module tb_instr_loader;

    localparam int DEPTH = 4;
    localparam int IW    = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [7:0]             in_byte;
    logic                   in_valid;
    logic                   in_ready;
    logic                   flush;
    logic [IW-1:0]          instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   drop_err;

    instr_loader #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .count       (count),
        .drop_err    (drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of complete words, a pending high byte, a flag.
    logic [15:0] mq[$];
    bit          m_has_hi = 1'b0;
    logic [7:0]  m_hi     = '0;
    bit          m_drop   = 1'b0;
    bit          m_known  = 1'b0;

    // Words the DUT handed to the core, for order checks.
    logic [15:0] popped[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare against model, advance model, clock.
    task automatic tick(input logic v, input logic [7:0] b, input logic r,
                        input logic f, input logic rs);
        bit exp_ready;
        in_valid    = v;
        in_byte     = b;
        instr_ready = r;
        flush       = f;
        rst         = rs;
        #1;
        exp_ready = f || !m_has_hi || (mq.size() < DEPTH);
        if (m_known) begin
            check("in_ready",    {31'd0, in_ready},    {31'd0, exp_ready});
            check("instr_valid", {31'd0, instr_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
            check("instr",       {16'd0, instr},       (mq.size() != 0) ? {16'd0, mq[0]} : 32'd0);
            check("count",       32'(count),           32'(mq.size()));
            check("drop_err",    {31'd0, drop_err},    {31'd0, m_drop});
        end
        if (!rs && !f && instr_valid && r)
            popped.push_back(instr);
        if (rs) begin
            mq.delete();
            m_has_hi = 1'b0;
            m_hi     = '0;
            m_drop   = 1'b0;
            m_known  = 1'b1;
        end else if (f) begin
            if (m_has_hi) m_drop = 1'b1;
            mq.delete();
            m_has_hi = 1'b0;
        end else begin
            if (r && mq.size() != 0)
                void'(mq.pop_front());
            if (v && exp_ready) begin
                if (!m_has_hi) begin
                    m_hi     = b;
                    m_has_hi = 1'b1;
                end else begin
                    mq.push_back({m_hi, b});
                    m_has_hi = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input logic r);
        tick(1'b1, w[15:8], r, 1'b0, 1'b0);
        tick(1'b1, w[7:0],  r, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic r, input int n);
        for (int i = 0; i < n; i++)
            tick(1'b0, 8'h00, r, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_popped(input string tag, input logic [15:0] exp[$]);
        check({tag, "_len"}, 32'(popped.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < popped.size(); i++)
            check(tag, {16'd0, popped[i]}, {16'd0, exp[i]});
    endtask

    logic [15:0] exp_words[$];

    initial begin
        in_valid    = 1'b0;
        in_byte     = '0;
        instr_ready = 1'b0;
        flush       = 1'b0;
        rst         = 1'b1;

        // Reset state.
        do_reset();
        check("rst_instr",    {16'd0, instr}, 32'h0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_count",    32'(count), 32'd0);

        // Basic load.
        tick(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        check("load_instr", {16'd0, instr}, 32'h1234);
        check("load_valid", {31'd0, instr_valid}, 32'd1);
        check("load_count", 32'(count), 32'd1);
        idle(1'b1, 2);

        // Fill and backpressure.
        do_reset();
        popped.delete();
        for (int i = 1; i <= 4; i++)
            send_word(16'hA000 + 16'(i), 1'b0);
        tick(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_count",    32'(count), 32'd4);
        tick(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 8'hCC, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 5);
        exp_words = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hBBCC};
        check_popped("bp_order", exp_words);

        // Concurrent stream with the core always ready.
        popped.delete();
        exp_words.delete();
        for (int i = 0; i < 8; i++) begin
            send_word(16'hC000 + 16'(i * 17), 1'b1);
            exp_words.push_back(16'hC000 + 16'(i * 17));
            check("stream_cnt_le1", {31'd0, (count <= 1)}, 32'd1);
        end
        idle(1'b1, 2);
        check_popped("stream_order", exp_words);

        // Flush mid-instruction.
        tick(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        check("flush_drop",  {31'd0, drop_err}, 32'd1);
        check("flush_count", 32'(count), 32'd0);
        tick(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        check("flush_next", {16'd0, instr}, 32'h0102);
        idle(1'b1, 2);

        // Reset mid-operation: three words buffered, assembler in LO.
        for (int i = 0; i < 3; i++)
            send_word(16'h7700 + 16'(i), 1'b0);
        tick(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_drop",  {31'd0, drop_err}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);

        // Empty pop and pointer wrap.
        idle(1'b1, 3);
        check("empty_pop_count", 32'(count), 32'd0);
        popped.delete();
        exp_words.delete();
        for (int i = 0; i < 10; i++) begin
            send_word(16'hD000 + 16'(i * 3), (i % 3) != 0);
            exp_words.push_back(16'hD000 + 16'(i * 3));
        end
        idle(1'b1, 6);
        check_popped("wrap_order", exp_words);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 255) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
